ddr3_avl_responder: RTL and testbench

//   Avalon-MM slave model of the DDR3 bridge port driven by mem_shim. It answers
//   ddr3_read/ddr3_write with waitrequest, fixed-latency in-order readdatavalid

---
 rtl/ddr3_avl_responder.sv | 198 +++++++++++++++++++
 tb/tb_ddr3_avl_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_avl_responder.sv
// Avalon-MM slave model of the mem_shim DDR3 port: fixed-latency in-order read bursts,
// byte-enabled 64-bit BRAM store, sticky window/protocol/write-after-read hazard flags.
module ddr3_avl_responder #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter logic [6:0]  WINDOW_HI  = 7'b0011000,
    parameter int unsigned RD_LATENCY = 8,
    parameter int unsigned MAX_PEND   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic [28:0] ddr3_addr,
    input  logic [7:0]  ddr3_burstcnt,
    input  logic        ddr3_read,
    input  logic        ddr3_write,
    input  logic [63:0] ddr3_writedata,
    input  logic [7:0]  ddr3_byteenable,
    output logic [63:0] ddr3_readdata,
    output logic        ddr3_readdatavalid,
    output logic        ddr3_waitrequest,
    output logic [8:0]  outstanding,
    output logic        err_window,
    output logic        err_proto,
    output logic        war_hazard
);

    localparam int unsigned DEPTH     = 1 << ADDR_BITS;
    localparam int unsigned PW        = $clog2(MAX_PEND);
    localparam logic [PW:0] PEND_FULL = (PW+1)'(MAX_PEND);
    localparam logic [15:0] LAT       = 16'(RD_LATENCY);
    localparam logic [63:0] BAD_DATA  = 64'hBAD0_BAD0_BAD0_BAD0;

    typedef enum logic {ST_IDLE, ST_WR_BURST} state_t;

    typedef struct packed {
        logic [28:0] addr;
        logic [7:0]  cnt;
        logic [15:0] due;
        logic        bad;
    } rd_cmd_t;

    state_t          r_state, w_state_nxt;
    logic [15:0]     r_cycle_cnt;
    rd_cmd_t         r_q [MAX_PEND];
    logic [PW-1:0]   r_q_wr, r_q_rd;
    logic [PW:0]     r_q_cnt;
    logic [28:0]     r_wr_addr;
    logic [7:0]      r_wr_k, r_wr_left;
    logic            r_wr_bad;
    logic            r_ret_active, r_ret_bad;
    logic [28:0]     r_ret_addr;
    logic [7:0]      r_ret_beat, r_ret_left;
    logic [63:0]     r_mem [DEPTH];
    logic [63:0]     r_rdata;
    logic            r_rvalid;
    logic [8:0]      r_outstanding;
    logic            r_err_window, r_err_proto, r_war;

    logic            w_waitreq, w_rd_acc, w_wr_acc, w_proto_ev, w_win_ev;
    logic            w_q_full, w_addr_bad, w_wr_bad, w_head_ready;
    logic            w_start, w_fetch, w_f_bad;
    logic [7:0]      w_cnt_eff, w_f_beat, w_f_left;
    logic [28:0]     w_f_addr;
    logic [ADDR_BITS-1:0] w_wr_idx, w_f_idx;
    logic [15:0]     w_due_diff;
    logic [9:0]      w_out_sum;
    rd_cmd_t         w_head;

    assign w_q_full   = (r_q_cnt == PEND_FULL);
    assign w_addr_bad = (ddr3_addr[28:22] != WINDOW_HI);
    assign w_cnt_eff  = (ddr3_burstcnt == 8'd0) ? 8'd1 : ddr3_burstcnt;

    // Head is due once cycle_cnt reaches due-1, so its first beat lands exactly at due.
    assign w_head       = r_q[r_q_rd];
    assign w_due_diff   = r_cycle_cnt + 16'd1 - w_head.due;
    assign w_head_ready = (r_q_cnt != '0) && ($signed(w_due_diff) >= 16'sd0);

    assign w_start  = !r_ret_active && w_head_ready;
    assign w_fetch  = w_start || r_ret_active;
    assign w_f_addr = w_start ? w_head.addr : r_ret_addr;
    assign w_f_beat = w_start ? 8'd0 : r_ret_beat;
    assign w_f_left = w_start ? w_head.cnt : r_ret_left;
    assign w_f_bad  = w_start ? w_head.bad : r_ret_bad;
    assign w_f_idx  = ADDR_BITS'(w_f_addr + 29'(w_f_beat));

    assign w_out_sum = {1'b0, r_outstanding} + (w_rd_acc ? {2'b00, w_cnt_eff} : 10'd0)
                     - {9'd0, w_fetch};

    // Command acceptance and write-burst sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_waitreq   = !rst_n || stall_i || (ddr3_read && w_q_full)
                    || (r_state == ST_IDLE && ddr3_read && ddr3_write);
        w_rd_acc    = 1'b0;
        w_wr_acc    = 1'b0;
        w_proto_ev  = 1'b0;
        w_win_ev    = 1'b0;
        w_wr_idx    = ADDR_BITS'(r_wr_addr + 29'(r_wr_k));
        w_wr_bad    = r_wr_bad;
        case (r_state)
            ST_IDLE: begin
                w_rd_acc   = ddr3_read && !ddr3_write && !w_waitreq;
                w_wr_acc   = ddr3_write && !ddr3_read && !w_waitreq;
                w_wr_idx   = ddr3_addr[ADDR_BITS-1:0];
                w_wr_bad   = w_addr_bad;
                w_proto_ev = (ddr3_read && ddr3_write)
                           || ((w_rd_acc || w_wr_acc) && ddr3_burstcnt == 8'd0);
                w_win_ev   = (w_rd_acc || w_wr_acc) && w_addr_bad;
                if (w_wr_acc && w_cnt_eff > 8'd1) w_state_nxt = ST_WR_BURST;
            end
            ST_WR_BURST: begin
                w_wr_acc   = ddr3_write && !w_waitreq;
                w_proto_ev = ddr3_read;
                if (w_wr_acc && r_wr_left == 8'd1) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt   <= 16'd0;
            r_q_wr        <= '0;
            r_q_rd        <= '0;
            r_q_cnt       <= '0;
            r_wr_addr     <= 29'd0;
            r_wr_k        <= 8'd0;
            r_wr_left     <= 8'd0;
            r_wr_bad      <= 1'b0;
            r_ret_active  <= 1'b0;
            r_ret_bad     <= 1'b0;
            r_ret_addr    <= 29'd0;
            r_ret_beat    <= 8'd0;
            r_ret_left    <= 8'd0;
            r_rdata       <= 64'd0;
            r_rvalid      <= 1'b0;
            r_outstanding <= 9'd0;
            r_err_window  <= 1'b0;
            r_err_proto   <= 1'b0;
            r_war         <= 1'b0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
            if (w_rd_acc) r_q_wr <= r_q_wr + PW'(1);
            if (w_start)  r_q_rd <= r_q_rd + PW'(1);
            r_q_cnt <= r_q_cnt + {{PW{1'b0}}, w_rd_acc} - {{PW{1'b0}}, w_start};
            if (w_wr_acc && r_state == ST_IDLE) begin
                r_wr_addr <= ddr3_addr;
                r_wr_k    <= 8'd1;
                r_wr_left <= w_cnt_eff - 8'd1;
                r_wr_bad  <= w_addr_bad;
            end else if (w_wr_acc) begin
                r_wr_k    <= r_wr_k + 8'd1;
                r_wr_left <= r_wr_left - 8'd1;
            end
            if (w_fetch) begin
                r_ret_active <= (w_f_left > 8'd1);
                r_ret_left   <= w_f_left - 8'd1;
                r_ret_beat   <= w_f_beat + 8'd1;
                r_ret_addr   <= w_f_addr;
                r_ret_bad    <= w_f_bad;
                r_rdata      <= w_f_bad ? BAD_DATA : r_mem[w_f_idx];
            end
            r_rvalid      <= w_fetch;
            r_outstanding <= (w_out_sum > 10'd511) ? 9'd511 : w_out_sum[8:0];
            if (w_proto_ev || w_out_sum > 10'd511) r_err_proto  <= 1'b1;
            if (w_win_ev)                          r_err_window <= 1'b1;
            if (w_wr_acc && r_outstanding != 9'd0) r_war        <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_acc) r_q[r_q_wr] <= '{addr: ddr3_addr, cnt: w_cnt_eff,
                                       due: r_cycle_cnt + LAT, bad: w_addr_bad};
    end

    // Backing store keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !w_wr_bad) begin
            for (int b = 0; b < 8; b++) begin
                if (ddr3_byteenable[b]) r_mem[w_wr_idx][8*b +: 8] <= ddr3_writedata[8*b +: 8];
            end
        end
    end

    assign ddr3_readdata      = r_rdata;
    assign ddr3_readdatavalid = r_rvalid;
    assign ddr3_waitrequest   = w_waitreq;
    assign outstanding        = r_outstanding;
    assign err_window         = r_err_window;
    assign err_proto          = r_err_proto;
    assign war_hazard         = r_war;

endmodule

// File: tb/tb_ddr3_avl_responder.sv
// Bench for ddr3_avl_responder: directed scenarios plus random traffic, every cycle
// compared against a beat-schedule / memory-image model of the port.
module tb_ddr3_avl_responder;

    localparam int          RD_LAT = 8;
    localparam int          NPEND  = 4;
    localparam logic [6:0]  WINHI  = 7'b0011000;
    localparam logic [63:0] BAD    = 64'hBAD0_BAD0_BAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst_n, stall_i, ddr3_read, ddr3_write;
    logic [28:0] ddr3_addr;
    logic [7:0]  ddr3_burstcnt, ddr3_byteenable;
    logic [63:0] ddr3_writedata, ddr3_readdata;
    logic        ddr3_readdatavalid, ddr3_waitrequest;
    logic [8:0]  outstanding;
    logic        err_window, err_proto, war_hazard;

    always #5 clk = ~clk;

    ddr3_avl_responder #(.ADDR_BITS(10), .WINDOW_HI(WINHI), .RD_LATENCY(RD_LAT), .MAX_PEND(NPEND)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .ddr3_addr(ddr3_addr),
        .ddr3_burstcnt(ddr3_burstcnt), .ddr3_read(ddr3_read), .ddr3_write(ddr3_write),
        .ddr3_writedata(ddr3_writedata), .ddr3_byteenable(ddr3_byteenable),
        .ddr3_readdata(ddr3_readdata), .ddr3_readdatavalid(ddr3_readdatavalid),
        .ddr3_waitrequest(ddr3_waitrequest), .outstanding(outstanding),
        .err_window(err_window), .err_proto(err_proto), .war_hazard(war_hazard));

    typedef struct { int stamp; logic [9:0] idx; logic bad; logic [63:0] data; } beat_t;

    int          n_total = 0, n_bad = 0, cyc = 0, n_beats = 0, last_stamp = 0;
    logic [63:0] last_obs = '0;
    logic [63:0] m_mem [1024];
    beat_t       m_beats [$];
    int          m_firsts [$];
    int          m_last = -100, m_wr_left = 0, m_wr_k = 0;
    logic [28:0] m_wr_base = '0;
    logic        m_wr_bad = 1'b0, e_proto = 1'b0, e_win = 1'b0, e_war = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [28:0] a, input logic [7:0] bc,
                         input logic [63:0] wd, input logic [7:0] be);
        ddr3_read = rd; ddr3_write = wr; ddr3_addr = a; ddr3_burstcnt = bc;
        ddr3_writedata = wd; ddr3_byteenable = be;
    endtask

    // One clock: check waitrequest, advance the model over the edge, then check outputs.
    task automatic tick(output bit acc);
        bit idle, ew, acc_rd, acc_wr, win_bad, ev;
        int qn, outs, eff, start;
        #1;
        idle = (m_wr_left == 0);
        qn = 0;
        foreach (m_firsts[i]) if (m_firsts[i] > cyc + 1) qn++;
        ew = !rst_n || stall_i || (ddr3_read && qn >= NPEND) || (idle && ddr3_read && ddr3_write);
        chk("waitrequest", 64'(ddr3_waitrequest), 64'(ew));
        acc_wr  = ddr3_write && !ew;
        acc_rd  = ddr3_read && !ew && idle;
        acc     = acc_wr || acc_rd;
        outs    = m_beats.size();
        win_bad = (ddr3_addr[28:22] != WINHI);
        eff     = (ddr3_burstcnt == 8'd0) ? 1 : int'(ddr3_burstcnt);
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_beats.delete(); m_firsts.delete();
            m_wr_left = 0; m_last = -100; e_proto = 0; e_win = 0; e_war = 0;
        end else begin
            if ((idle && ddr3_read && ddr3_write) || (!idle && ddr3_read)
                || (idle && acc && ddr3_burstcnt == 8'd0)) e_proto = 1;
            if (idle && acc && win_bad) e_win = 1;
            if (acc_wr) begin
                if (outs != 0) e_war = 1;
                if (idle) begin
                    m_wr_base = ddr3_addr; m_wr_k = 0; m_wr_bad = win_bad; m_wr_left = eff;
                end
                if (!m_wr_bad) begin
                    for (int b = 0; b < 8; b++)
                        if (ddr3_byteenable[b])
                            m_mem[10'(m_wr_base + 29'(m_wr_k))][8*b +: 8] = ddr3_writedata[8*b +: 8];
                end
                m_wr_k++; m_wr_left--;
            end
            if (acc_rd) begin
                start = (cyc + RD_LAT > m_last + 1) ? cyc + RD_LAT : m_last + 1;
                m_firsts.push_back(start);
                for (int i = 0; i < eff; i++)
                    m_beats.push_back('{start + i, 10'(ddr3_addr + 29'(i)), win_bad, 64'd0});
                m_last = start + eff - 1;
            end
        end
        while (m_firsts.size() > 0 && m_firsts[0] <= cyc) void'(m_firsts.pop_front());
        @(negedge clk);
        ev = (m_beats.size() > 0) && (m_beats[0].stamp == cyc + 1);
        chk("readdatavalid", 64'(ddr3_readdatavalid), 64'(ev));
        if (ev) begin
            chk("readdata", ddr3_readdata, m_beats[0].data);
            last_obs = ddr3_readdata; last_stamp = cyc + 1; n_beats++;
            void'(m_beats.pop_front());
        end
        if (!rst_n) chk("reset_readdata", ddr3_readdata, 64'd0);
        chk("outstanding", 64'(outstanding), 64'(m_beats.size()));
        chk("err_proto", 64'(err_proto), 64'(e_proto));
        chk("err_window", 64'(err_window), 64'(e_win));
        chk("war_hazard", 64'(war_hazard), 64'(e_war));
        // Beat sampled two edges ahead sees every write accepted up to now.
        foreach (m_beats[i])
            if (m_beats[i].stamp == cyc + 2)
                m_beats[i].data = m_beats[i].bad ? BAD : m_mem[m_beats[i].idx];
    endtask

    task automatic do_cmd(input logic rd, input logic wr, input logic [28:0] a, input logic [7:0] bc,
                          input logic [63:0] wd, input logic [7:0] be, output int edge_no);
        bit acc = 0;
        drive(rd, wr, a, bc, wd, be);
        for (int k = 0; k < 50 && !acc; k++) tick(acc);
        chk("accept", 64'(acc), 64'd1);
        edge_no = cyc;
        drive(0, 0, '0, 8'd1, '0, '0);
    endtask

    task automatic idle_ticks(input int n);
        bit d;
        for (int k = 0; k < n; k++) tick(d);
    endtask

    task automatic wait_beats(input int target);
        bit d;
        for (int k = 0; k < 100 && n_beats < target; k++) tick(d);
        chk("beat_wait", 64'(n_beats >= target), 64'd1);
    endtask

    initial begin
        int t, t0, t4, e, nb;
        logic [28:0] a;
        logic [63:0] d [4];
        bit dd;
        rst_n = 0; stall_i = 0;
        drive(0, 0, '0, 8'd1, '0, '0);
        @(negedge clk);
        idle_ticks(2);
        chk("reset_waitreq_low_rst", 64'(ddr3_waitrequest), 64'd1);
        rst_n = 1;
        idle_ticks(1);

        // Fill the whole store through aliased upper index bits.
        for (int i = 0; i < 1024; i++)
            do_cmd(0, 1, {WINHI, 12'(i * 7), 10'(i)}, 8'd1, {$urandom, $urandom}, 8'hFF, e);

        // T1: write then read, first beat RD_LAT after accept.
        a = {WINHI, 22'h123456};
        do_cmd(0, 1, a, 8'd1, 64'hDEADBEEF, 8'hFF, e);
        nb = n_beats;
        do_cmd(1, 0, a, 8'd1, '0, '0, t);
        wait_beats(nb + 1);
        chk("t1_latency", 64'(last_stamp), 64'(t + RD_LAT));
        chk("t1_data", last_obs, 64'hDEADBEEF);

        // T2: partial byte enable merge.
        a = {WINHI, 22'h00002A};
        do_cmd(0, 1, a, 8'd1, 64'h1111_1111_1111_1111, 8'hFF, e);
        do_cmd(0, 1, a, 8'd1, 64'h2222_2222_2222_2222, 8'h0F, e);
        nb = n_beats;
        do_cmd(1, 0, a, 8'd1, '0, '0, t);
        wait_beats(nb + 1);
        chk("t2_merge", last_obs, 64'h1111_1111_2222_2222);

        // T3: queue fills at four, fifth read held until the head starts.
        nb = n_beats;
        do_cmd(1, 0, {WINHI, 22'h000100}, 8'd1, '0, '0, t0);
        for (int i = 1; i < 4; i++) do_cmd(1, 0, {WINHI, 22'(256 + i)}, 8'd1, '0, '0, e);
        do_cmd(1, 0, {WINHI, 22'h000104}, 8'd1, '0, '0, t4);
        chk("t3_fifth_accept", 64'(t4), 64'(t0 + RD_LAT));
        wait_beats(nb + 5);
        chk("t3_fifth_beat", 64'(last_stamp), 64'(t0 + 2 * RD_LAT));

        // T4: write to a pending read address before its beat.
        a = {WINHI, 22'h155555};
        do_cmd(0, 1, a, 8'd1, 64'h0123_4567_89AB_CDEF, 8'hFF, e);
        nb = n_beats;
        do_cmd(1, 0, a, 8'd1, '0, '0, t);
        idle_ticks(2);
        do_cmd(0, 1, a, 8'd1, 64'hCAFE_F00D_1234_5678, 8'hFF, e);
        wait_beats(nb + 1);
        chk("t4_war", 64'(war_hazard), 64'd1);
        chk("t4_data", last_obs, 64'hCAFE_F00D_1234_5678);

        // T5: out-of-window read.
        nb = n_beats;
        do_cmd(1, 0, 29'h0, 8'd1, '0, '0, t);
        wait_beats(nb + 1);
        chk("t5_bad_data", last_obs, BAD);
        chk("t5_window", 64'(err_window), 64'd1);

        // T6: burst write across index wrap, burst read cut by reset, re-read.
        a = {WINHI, 22'h0003FE};
        for (int k = 0; k < 4; k++) d[k] = {$urandom, $urandom};
        do_cmd(0, 1, a, 8'd4, d[0], 8'hFF, e);
        for (int k = 1; k < 4; k++) do_cmd(0, 1, a, 8'd0, d[k], 8'hFF, e);
        nb = n_beats;
        do_cmd(1, 0, a, 8'd4, '0, '0, t);
        wait_beats(nb + 2);
        rst_n = 0;
        tick(dd);
        rst_n = 1;
        chk("t6_valid_after_rst", 64'(ddr3_readdatavalid), 64'd0);
        chk("t6_outs_after_rst", 64'(outstanding), 64'd0);
        nb = n_beats;
        do_cmd(1, 0, a, 8'd4, '0, '0, t);
        wait_beats(nb + 4);
        chk("t6_reread_last", last_obs, d[3]);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [6:0] hi;
            r  = $urandom_range(0, 9);
            hi = ($urandom_range(0, 9) == 0) ? 7'($urandom) : WINHI;
            stall_i = ($urandom_range(0, 4) == 0);
            rst_n   = ($urandom_range(0, 199) != 0);
            drive(r <= 2 || r == 6, (r >= 3 && r <= 6), {hi, 22'($urandom)},
                  8'($urandom_range(0, 6)), {$urandom, $urandom}, 8'($urandom));
            tick(dd);
        end
        stall_i = 0; rst_n = 1;
        drive(0, 0, '0, 8'd1, '0, '0);
        idle_ticks(40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
